// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte port between NUM_REQ byte streams.
// A grant lasts one message, capped at MAX_BURST bytes, and drops on an owner stall.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic                          tx_valid_o,
    input  logic                          tx_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]    tx_id_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BW  = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] BURST_LAST = (MAX_BURST > 0) ? BW'(MAX_BURST - 1) : '0;
    localparam logic [TW-1:0] IDLE_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t             state;
    logic [IDW-1:0]     owner;
    logic [IDW-1:0]     last_owner;
    logic [NUM_REQ-1:0] grant_q;
    logic               busy_q;
    logic [BW-1:0]      beat_cnt;
    logic [TW-1:0]      idle_cnt;

    logic               pick_found;
    logic [IDW-1:0]     pick_idx;
    logic               owner_valid;
    logic               owner_last;
    logic               beat;
    logic               cap_hit;
    logic               timeout_hit;
    logic               rel_now;

    // Search starts just after the previous owner, so a releasing requester goes last.
    always_comb begin : rr_pick
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!pick_found && req_valid_i[(int'(last_owner) + i) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDW'((int'(last_owner) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin : release_logic
        owner_valid = req_valid_i[owner];
        owner_last  = req_last_i[owner];
        beat        = (state == S_GRANT) && owner_valid && tx_ready_i;
        cap_hit     = (MAX_BURST != 0) && (beat_cnt == BURST_LAST);
        timeout_hit = (TIMEOUT != 0) && !owner_valid && (idle_cnt == IDLE_LAST);
        rel_now     = (state == S_GRANT) && ((beat && (owner_last || cap_hit)) || timeout_hit);
    end

    // The byte path is a pure pass-through while granted so a byte costs no extra cycle.
    always_comb begin : datapath
        tx_data_o   = '0;
        tx_valid_o  = 1'b0;
        req_ready_o = '0;
        if (state == S_GRANT) begin
            tx_data_o          = req_data_i[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
            tx_valid_o         = owner_valid;
            req_ready_o[owner] = tx_ready_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            owner      <= '0;
            last_owner <= IDW'(NUM_REQ - 1);
            grant_q    <= '0;
            busy_q     <= 1'b0;
            beat_cnt   <= '0;
            idle_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        state    <= S_GRANT;
                        owner    <= pick_idx;
                        grant_q  <= NUM_REQ'(1) << pick_idx;
                        busy_q   <= 1'b1;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    idle_cnt <= owner_valid ? '0 : idle_cnt + 1'b1;
                    if (rel_now) begin
                        state      <= S_IDLE;
                        grant_q    <= '0;
                        busy_q     <= 1'b0;
                        last_owner <= owner;
                    end
                end
            endcase
        end
    end

    assign tx_id_o = owner;
    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a message-level
// round-robin model: each grant serves one message or MAX_BURST bytes.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [1:0]    tx_id;
    logic [N-1:0]  grant;
    logic          busy;

    uart_tx_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_data_i (req_data),
        .req_valid_i(req_valid),
        .req_last_i (req_last),
        .req_ready_o(req_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .tx_id_o    (tx_id),
        .grant_o    (grant),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] msg_data[N][64];
    logic       msg_last[N][64];
    int         len[N];
    int         head[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
        req_valid[k]         = v;
        req_data[k*DW +: DW] = d;
        req_last[k]          = l;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic clear_msgs();
        for (int k = 0; k < N; k++) begin
            len[k]  = 0;
            head[k] = 0;
        end
    endtask

    task automatic add_msg(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            msg_data[k][len[k]] = 8'($urandom);
            msg_last[k][len[k]] = (i == n - 1);
            len[k]++;
        end
    endtask

    // Expected beat order: serve requesters round-robin, each turn ending at a
    // message end or after MB bytes, whichever comes first.
    task automatic build_expected();
        int h[N];
        int last;
        int k;
        int n;
        bit stop;
        bit any;
        exp_q.delete();
        for (int i = 0; i < N; i++) h[i] = 0;
        last = N - 1;
        forever begin
            any = 1'b0;
            k   = 0;
            for (int i = 1; i <= N; i++) begin
                if (!any && h[(last + i) % N] < len[(last + i) % N]) begin
                    any = 1'b1;
                    k   = (last + i) % N;
                end
            end
            if (!any) break;
            n = 0;
            do begin
                exp_q.push_back('{id: 2'(k), data: msg_data[k][h[k]]});
                n++;
                stop = msg_last[k][h[k]] || (MB != 0 && n == MB);
                h[k]++;
            end while (!stop);
            last = k;
        end
    endtask

    task automatic run_stream(input string tag, input bit rnd_ready, input int max_cycles);
        logic [N-1:0] prev_grant;
        beat_t        e;
        int           cycles;
        do_reset();
        build_expected();
        prev_grant = '0;
        cycles     = 0;
        while (exp_q.size() > 0 && cycles < max_cycles) begin
            for (int k = 0; k < N; k++) begin
                if (head[k] < len[k]) set_req(k, 1'b1, msg_data[k][head[k]], msg_last[k][head[k]]);
                else set_req(k, 1'b0, 8'h00, 1'b0);
            end
            tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (grant != '0 && prev_grant != '0)
                check($sformatf("%s bubble", tag), 32'(grant), 32'(prev_grant));
            prev_grant = grant;
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("%s extra beat req%0d", tag, k), 32'(1), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("%s id", tag), 32'(k), 32'(e.id));
                        check($sformatf("%s data", tag), 32'(tx_data), 32'(e.data));
                        check($sformatf("%s tx_id", tag), 32'(tx_id), 32'(e.id));
                        check($sformatf("%s grant", tag), 32'(grant), 32'(1) << e.id);
                    end
                    head[k]++;
                end
            end
            cyc();
            cycles++;
        end
        check($sformatf("%s beats left", tag), 32'(exp_q.size()), 32'(0));
        clear_inputs();
        cyc();
    endtask

    initial begin
        int nm;
        rst_n = 1'b0;
        clear_inputs();

        // Reset holds everything quiet even with all requesters asking.
        req_valid = '1;
        tx_ready  = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        check("rst grant", 32'(grant), 32'(0));
        check("rst busy", 32'(busy), 32'(0));
        check("rst tx_valid", 32'(tx_valid), 32'(0));
        check("rst req_ready", 32'(req_ready), 32'(0));
        check("rst tx_data", 32'(tx_data), 32'(0));
        check("rst tx_id", 32'(tx_id), 32'(0));

        // Single requester, three bytes on consecutive cycles.
        do_reset();
        tx_ready = 1'b1;
        set_req(2, 1'b1, 8'hA1, 1'b0);
        @(negedge clk);
        check("s1 pre grant", 32'(grant), 32'(0));
        cyc();
        @(negedge clk);
        check("s1 grant", 32'(grant), 32'h4);
        check("s1 tx_id", 32'(tx_id), 32'(2));
        check("s1 busy", 32'(busy), 32'(1));
        check("s1 ready", 32'(req_ready), 32'h4);
        check("s1 byte0", 32'(tx_data), 32'hA1);
        cyc();
        set_req(2, 1'b1, 8'hA2, 1'b0);
        @(negedge clk);
        check("s1 byte1", 32'(tx_data), 32'hA2);
        cyc();
        set_req(2, 1'b1, 8'hA3, 1'b1);
        @(negedge clk);
        check("s1 byte2", 32'(tx_data), 32'hA3);
        check("s1 valid", 32'(tx_valid), 32'(1));
        cyc();
        set_req(2, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("s1 released", 32'(grant), 32'(0));
        check("s1 not busy", 32'(busy), 32'(0));

        // Backpressure: ready 1,0,0,1 over bytes 0x55 and 0x66.
        do_reset();
        set_req(0, 1'b1, 8'h55, 1'b0);
        cyc();
        tx_ready = 1'b1;
        @(negedge clk);
        check("bp byte0", 32'(tx_data), 32'h55);
        check("bp ready0", 32'(req_ready), 32'h1);
        cyc();
        set_req(0, 1'b1, 8'h66, 1'b1);
        tx_ready = 1'b0;
        @(negedge clk);
        check("bp hold1 data", 32'(tx_data), 32'h66);
        check("bp hold1 ready", 32'(req_ready), 32'h0);
        cyc();
        @(negedge clk);
        check("bp hold2 data", 32'(tx_data), 32'h66);
        check("bp hold2 grant", 32'(grant), 32'h1);
        cyc();
        tx_ready = 1'b1;
        @(negedge clk);
        check("bp ready1", 32'(req_ready), 32'h1);
        cyc();
        set_req(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("bp released", 32'(grant), 32'(0));

        // Stall timeout: owner goes quiet after one byte; requester 1 waits.
        do_reset();
        tx_ready = 1'b1;
        set_req(0, 1'b1, 8'h11, 1'b0);
        set_req(1, 1'b1, 8'h22, 1'b1);
        cyc();
        @(negedge clk);
        check("to grant0", 32'(grant), 32'h1);
        cyc();
        set_req(0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            if (i == TO - 1) begin
                check("to hold grant", 32'(grant), 32'h1);
                check("to hold ready", 32'(req_ready), 32'h1);
                check("to hold valid", 32'(tx_valid), 32'(0));
            end
            cyc();
        end
        @(negedge clk);
        check("to released", 32'(grant), 32'(0));
        cyc();
        @(negedge clk);
        check("to grant1", 32'(grant), 32'h2);
        check("to data1", 32'(tx_data), 32'h22);

        // Reset after byte 5 of 10 aborts the grant; priority restarts at 0.
        do_reset();
        tx_ready = 1'b1;
        set_req(2, 1'b1, 8'h30, 1'b0);
        cyc();
        for (int b = 0; b < 5; b++) begin
            set_req(2, 1'b1, 8'(8'h30 + b), 1'b0);
            @(negedge clk);
            check("mr byte", 32'(tx_data), 32'(8'h30 + b));
            cyc();
        end
        rst_n = 1'b0;
        set_req(2, 1'b1, 8'h35, 1'b0);
        set_req(0, 1'b1, 8'h77, 1'b1);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("mr grant", 32'(grant), 32'(0));
        check("mr busy", 32'(busy), 32'(0));
        check("mr tx_valid", 32'(tx_valid), 32'(0));
        check("mr ready", 32'(req_ready), 32'(0));
        check("mr tx_data", 32'(tx_data), 32'(0));
        check("mr tx_id", 32'(tx_id), 32'(0));
        cyc();
        @(negedge clk);
        check("mr regrant", 32'(grant), 32'h1);
        check("mr regrant data", 32'(tx_data), 32'h77);

        // Four one-byte requesters: order 0,1,2,3,0.
        clear_msgs();
        add_msg(0, 1);
        add_msg(0, 1);
        add_msg(1, 1);
        add_msg(2, 1);
        add_msg(3, 1);
        run_stream("rr", 1'b0, 200);

        // Burst cap: 40-byte message on req 1 against 20 bytes on req 3.
        clear_msgs();
        add_msg(1, 40);
        add_msg(3, 20);
        run_stream("cap", 1'b0, 400);

        // Random message mixes with random core backpressure.
        for (int it = 0; it < 3; it++) begin
            clear_msgs();
            for (int k = 0; k < N; k++) begin
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) add_msg(k, $urandom_range(1, 20));
            end
            if (len[0] + len[1] + len[2] + len[3] == 0) add_msg(0, 1);
            run_stream($sformatf("rnd%0d", it), 1'b1, 3000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
